// File: rtl/pid_sequencer.sv
// pid_sequencer: sample-rate sequencer for an external PID datapath.
// Each sample it requests a measurement, latches the setpoint and gains,
// steps the datapath once, then saturates and publishes the control word.
// Optional measurement timeout: define PID_SEQ_TIMEOUT_EN to enable it.
// When it is undefined, WAIT_MEAS waits indefinitely and fault stays 0.
module pid_sequencer #(
   parameter int unsigned SAMPLE_DIV     = 100000,
   parameter int unsigned PV_WIDTH       = 9,
   parameter int unsigned GAIN_WIDTH     = 16,
   parameter int unsigned CONTROL_WIDTH  = 16,
   parameter int          CTRL_LIMIT     = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            run_i,
   input  logic [PV_WIDTH-1:0]             setpoint_i,
   output logic                            meas_req_o,
   input  logic                            meas_valid_i,
   input  logic [PV_WIDTH-1:0]             meas_data_i,
   input  logic                            gain_wr_i,
   input  logic [1:0]                      gain_sel_i,
   input  logic [GAIN_WIDTH-1:0]           gain_data_i,
   output logic                            pid_en_o,
   output logic                            pid_clk_en_o,
   output logic [PV_WIDTH-1:0]             pid_setpoint_o,
   output logic [PV_WIDTH-1:0]             pid_feedback_o,
   output logic [GAIN_WIDTH-1:0]           pid_k_p_o,
   output logic [GAIN_WIDTH-1:0]           pid_k_i_o,
   output logic [GAIN_WIDTH-1:0]           pid_k_d_o,
   input  logic signed [CONTROL_WIDTH-1:0] pid_control_i,
   output logic signed [CONTROL_WIDTH-1:0] ctrl_out_o,
   output logic                            ctrl_valid_o,
   output logic                            busy_o,
   output logic                            overrun_o,
   output logic                            fault_o
);

   localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   // Reject configurations the sequencer cannot honour.
   if (SAMPLE_DIV < 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("pid_sequencer: SAMPLE_DIV must be >= 8 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [2:0] {
      StIdle,
      StWaitTick,
      StReq,
      StWaitMeas,
      StStep,
      StCapture,
      StOut
   } state_e;

   state_e                            state_q, state_d;
   logic [CntW-1:0]                   cnt_q, cnt_d;
   logic                              tick;
   logic                              tmo_hit;
   logic                              overrun_q, overrun_d;
   logic [PV_WIDTH-1:0]               setpoint_q, setpoint_d;
   logic [PV_WIDTH-1:0]               feedback_q, feedback_d;
   logic [GAIN_WIDTH-1:0]             kp_sh_q, kp_sh_d, ki_sh_q, ki_sh_d, kd_sh_q, kd_sh_d;
   logic [GAIN_WIDTH-1:0]             kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
   logic signed [CONTROL_WIDTH-1:0]   ctrl_q, ctrl_d;
   logic signed [CONTROL_WIDTH-1:0]   lim_pos, lim_neg, ctrl_sat;

   // Sample counter: free-runs while enabled, tick on the terminal count.
   always_comb begin
      tick  = run_i && (cnt_q == CntW'(SAMPLE_DIV - 1));
      cnt_d = cnt_q + CntW'(1);
      if (!run_i || tick) begin
         cnt_d = '0;
      end
   end

   // Clamp the datapath result to the symmetric control range.
   always_comb begin
      lim_pos  = CONTROL_WIDTH'(CTRL_LIMIT);
      lim_neg  = -lim_pos;
      ctrl_sat = pid_control_i;
      if (pid_control_i > lim_pos) begin
         ctrl_sat = lim_pos;
      end else if (pid_control_i < lim_neg) begin
         ctrl_sat = lim_neg;
      end
   end

   // Shadow gains accept writes in any state; selector 3 is a no-op.
   always_comb begin
      kp_sh_d = kp_sh_q;
      ki_sh_d = ki_sh_q;
      kd_sh_d = kd_sh_q;
      if (gain_wr_i) begin
         case (gain_sel_i)
            2'd0:    kp_sh_d = gain_data_i;
            2'd1:    ki_sh_d = gain_data_i;
            2'd2:    kd_sh_d = gain_data_i;
            default: ;
         endcase
      end
   end

`ifdef PID_SEQ_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            fault_q, fault_d;

   // Measurement watchdog: counts cycles spent in WAIT_MEAS; fault is sticky until run drops.
   always_comb begin
      tmo_d   = (state_q == StWaitMeas) ? tmo_q + TmoW'(1) : '0;
      tmo_hit = (state_q == StWaitMeas) && !meas_valid_i && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
      fault_d = run_i ? (fault_q | tmo_hit) : 1'b0;
   end

   // Watchdog state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         fault_q <= fault_d;
      end
   end

   assign fault_o = fault_q;
`else
   assign tmo_hit = 1'b0;
   assign fault_o = 1'b0;
`endif

   // Sequencer next state and the registers it loads at each phase of a sample.
   always_comb begin
      state_d    = state_q;
      overrun_d  = overrun_q;
      setpoint_d = setpoint_q;
      feedback_d = feedback_q;
      kp_d       = kp_q;
      ki_d       = ki_q;
      kd_d       = kd_q;
      ctrl_d     = ctrl_q;
      if (!run_i) begin
         state_d   = StIdle;
         overrun_d = 1'b0;
      end else begin
         // A tick while a sample is still in flight is dropped.
         if (tick && state_q != StIdle && state_q != StWaitTick) begin
            overrun_d = 1'b1;
         end
         case (state_q)
            StIdle: state_d = StWaitTick;
            StWaitTick: begin
               if (tick) begin
                  state_d    = StReq;
                  kp_d       = kp_sh_q;
                  ki_d       = ki_sh_q;
                  kd_d       = kd_sh_q;
                  setpoint_d = setpoint_i;
               end
            end
            StReq: state_d = StWaitMeas;
            StWaitMeas: begin
               if (meas_valid_i) begin
                  feedback_d = meas_data_i;
                  state_d    = StStep;
               end else if (tmo_hit) begin
                  state_d = StWaitTick;
               end
            end
            StStep: state_d = StCapture;
            StCapture: begin
               ctrl_d  = ctrl_sat;
               state_d = StOut;
            end
            StOut:   state_d = StWaitTick;
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath-facing registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         overrun_q  <= 1'b0;
         setpoint_q <= '0;
         feedback_q <= '0;
         kp_sh_q    <= '0;
         ki_sh_q    <= '0;
         kd_sh_q    <= '0;
         kp_q       <= '0;
         ki_q       <= '0;
         kd_q       <= '0;
         ctrl_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         overrun_q  <= overrun_d;
         setpoint_q <= setpoint_d;
         feedback_q <= feedback_d;
         kp_sh_q    <= kp_sh_d;
         ki_sh_q    <= ki_sh_d;
         kd_sh_q    <= kd_sh_d;
         kp_q       <= kp_d;
         ki_q       <= ki_d;
         kd_q       <= kd_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign meas_req_o     = (state_q == StReq);
   assign pid_clk_en_o   = (state_q == StStep);
   assign ctrl_valid_o   = (state_q == StOut);
   assign pid_en_o       = (state_q != StIdle);
   assign busy_o         = (state_q != StIdle) && (state_q != StWaitTick);
   assign overrun_o      = overrun_q;
   assign pid_setpoint_o = setpoint_q;
   assign pid_feedback_o = feedback_q;
   assign pid_k_p_o      = kp_q;
   assign pid_k_i_o      = ki_q;
   assign pid_k_d_o      = kd_q;
   assign ctrl_out_o     = ctrl_q;

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed bench for pid_sequencer with SAMPLE_DIV=20, CTRL_LIMIT=1000, TIMEOUT_CYCLES=10.
module tb_pid_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [8:0]  setpoint = '0;
   logic        meas_req;
   logic        meas_valid = 1'b0;
   logic [8:0]  meas_data = '0;
   logic        gain_wr = 1'b0;
   logic [1:0]  gain_sel = '0;
   logic [15:0] gain_data = '0;
   logic        pid_en, pid_clk_en, ctrl_valid, busy, overrun, fault;
   logic [8:0]  pid_setpoint, pid_feedback;
   logic [15:0] pid_k_p, pid_k_i, pid_k_d;
   logic [15:0] pid_control = '0;
   logic [15:0] ctrl_out;

   int unsigned cyc_cnt = 0;
   int unsigned clk_en_pulses = 0;
   int unsigned valid_pulses = 0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   pid_sequencer #(
      .SAMPLE_DIV    (20),
      .PV_WIDTH      (9),
      .GAIN_WIDTH    (16),
      .CONTROL_WIDTH (16),
      .CTRL_LIMIT    (1000),
      .TIMEOUT_CYCLES(10)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .run_i         (run),
      .setpoint_i    (setpoint),
      .meas_req_o    (meas_req),
      .meas_valid_i  (meas_valid),
      .meas_data_i   (meas_data),
      .gain_wr_i     (gain_wr),
      .gain_sel_i    (gain_sel),
      .gain_data_i   (gain_data),
      .pid_en_o      (pid_en),
      .pid_clk_en_o  (pid_clk_en),
      .pid_setpoint_o(pid_setpoint),
      .pid_feedback_o(pid_feedback),
      .pid_k_p_o     (pid_k_p),
      .pid_k_i_o     (pid_k_i),
      .pid_k_d_o     (pid_k_d),
      .pid_control_i (pid_control),
      .ctrl_out_o    (ctrl_out),
      .ctrl_valid_o  (ctrl_valid),
      .busy_o        (busy),
      .overrun_o     (overrun),
      .fault_o       (fault)
   );

   always #5 clk = ~clk;

   // Cycle stamp and pulse tallies, sampled at the active edge.
   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (pid_clk_en) clk_en_pulses <= clk_en_pulses + 1;
      if (ctrl_valid) valid_pulses <= valid_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait (bounded) for a meas_req pulse; returns its cycle stamp.
   task automatic wait_req(input string tag, output int unsigned at);
      int n = 0;
      while (meas_req !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      assert (meas_req === 1'b1)
      else begin
         miscompares++;
         $error("FAIL %s: observed meas_req=%b expected 1 within 60 cycles", tag, meas_req);
      end
      at = cyc_cnt;
   endtask

   initial begin
      int unsigned r0, r1, r2, r3, r4, r5, r6, r7;

      // Reset state
      cyc(3);
      check("rst_flags", {25'd0, pid_en, pid_clk_en, meas_req, ctrl_valid, busy, overrun, fault},
            32'd0);
      check("rst_ctrl_out", {16'd0, ctrl_out}, 32'd0);
      check("rst_setpoint_feedback", {14'd0, pid_setpoint, pid_feedback}, 32'd0);
      check("rst_kp", {16'd0, pid_k_p}, 32'd0);
      check("rst_ki_kd", {pid_k_i, pid_k_d}, 32'd0);
      reset = 1'b0;
      cyc(1);

      // Shadow writes in IDLE do not reach the datapath
      gain_wr = 1'b1; gain_sel = 2'd0; gain_data = 16'h0100;
      cyc(1);
      gain_sel = 2'd1; gain_data = 16'h0020;
      cyc(1);
      gain_sel = 2'd2; gain_data = 16'h0008;
      cyc(1);
      gain_wr = 1'b0;
      check("kp_not_applied_in_idle", {16'd0, pid_k_p}, 32'd0);

      // Sample 1: saturate high
      setpoint = 9'd100;
      pid_control = 16'd2000;
      run = 1'b1;
      check("idle_pid_en", {31'd0, pid_en}, 32'd0);
      cyc(1);
      check("wait_tick_en_busy", {30'd0, pid_en, busy}, 32'b10);
      wait_req("req1", r0);
      check("req1_kp", {16'd0, pid_k_p}, 32'h0100);
      check("req1_ki_kd", {pid_k_i, pid_k_d}, {16'h0020, 16'h0008});
      check("req1_setpoint", {23'd0, pid_setpoint}, 32'd100);
      cyc(1);
      check("req_one_cycle", {30'd0, meas_req, busy}, 32'b01);
      cyc(2);
      meas_valid = 1'b1; meas_data = 9'd90;
      cyc(1);
      meas_valid = 1'b0;
      check("step_clk_en", {31'd0, pid_clk_en}, 32'd1);
      check("feedback_90", {23'd0, pid_feedback}, 32'd90);
      cyc(1);
      check("capture_no_clk_en", {31'd0, pid_clk_en}, 32'd0);
      cyc(1);
      check("valid_3_after_meas", {31'd0, ctrl_valid}, 32'd1);
      check("sat_pos", {16'd0, ctrl_out}, 32'h03E8);
      cyc(1);
      check("out_one_cycle", {30'd0, ctrl_valid, busy}, 32'd0);
      check("pulses_s1", clk_en_pulses * 256 + valid_pulses, 32'h0101);

      // Sample 2: saturate low, gain writes mid-sample
      pid_control = 16'hFA24;  // -1500
      wait_req("req2", r1);
      check("period_1_2", r1 - r0, 32'd20);
      cyc(1);
      gain_wr = 1'b1; gain_sel = 2'd0; gain_data = 16'h0180;
      cyc(1);
      gain_sel = 2'd3; gain_data = 16'hFFFF;
      cyc(1);
      gain_wr = 1'b0;
      meas_valid = 1'b1; meas_data = 9'd110;
      check("kp_held_mid_sample", {16'd0, pid_k_p}, 32'h0100);
      cyc(1);
      meas_valid = 1'b0;
      cyc(2);
      check("sat_neg", {15'd0, ctrl_valid, ctrl_out}, {15'd0, 1'b1, 16'hFC18});
      cyc(1);

      // Write coinciding with REQ entry (cycle R+19) applies next sample
      cyc(12);
      gain_wr = 1'b1; gain_sel = 2'd1; gain_data = 16'h0040;
      cyc(1);
      gain_wr = 1'b0;
      r2 = cyc_cnt;
      check("req3_on_time", {31'd0, meas_req}, 32'd1);
      check("period_2_3", r2 - r1, 32'd20);
      check("kp_new_at_req", {16'd0, pid_k_p}, 32'h0180);
      check("ki_old_kd_sel3_ignored", {pid_k_i, pid_k_d}, {16'h0020, 16'h0008});

      // Sample 3: in-range negative
      pid_control = 16'hFFF9;  // -7
      cyc(3);
      meas_valid = 1'b1; meas_data = 9'd120;
      cyc(1);
      meas_valid = 1'b0;
      cyc(2);
      check("in_range_neg", {15'd0, ctrl_valid, ctrl_out}, {15'd0, 1'b1, 16'hFFF9});
      cyc(1);

      // Sample 4: late measurement -> overrun
      pid_control = 16'd500;
      wait_req("req4", r3);
      check("ki_new_next_sample", {16'd0, pid_k_i}, 32'h0040);
      check("no_overrun_yet", {31'd0, overrun}, 32'd0);
      cyc(25);
      check("overrun_set", {30'd0, overrun, busy}, 32'b11);
      meas_valid = 1'b1; meas_data = 9'd130;
      cyc(1);
      meas_valid = 1'b0;
      check("late_meas_processed", {22'd0, pid_clk_en, pid_feedback}, {22'd0, 1'b1, 9'd130});
      cyc(2);
      check("late_ctrl_out", {15'd0, ctrl_valid, ctrl_out}, {15'd0, 1'b1, 16'd500});
      wait_req("req5", r4);
      check("next_sample_next_tick", r4 - r3, 32'd40);
      check("overrun_sticky", {31'd0, overrun}, 32'd1);
      check("pulses_s4", clk_en_pulses * 256 + valid_pulses, 32'h0404);

      // Sample 5: run dropped in WAIT_MEAS
      cyc(1);
      run = 1'b0;
      cyc(1);
      check("drop_idle", {28'd0, pid_en, busy, overrun, fault}, 32'd0);
      meas_valid = 1'b1; meas_data = 9'd200;
      cyc(1);
      meas_valid = 1'b0;
      check("meas_ignored_idle", {23'd0, pid_feedback}, 32'd130);
      check("ctrl_out_held", {16'd0, ctrl_out}, 32'd500);
      cyc(3);
      check("no_clk_en_after_drop", clk_en_pulses, 32'd4);

      // Measurement timeout
      run = 1'b1;
      wait_req("req_tmo", r5);
`ifdef PID_SEQ_TIMEOUT_EN
      cyc(10);
      check("tmo_before", {30'd0, fault, busy}, 32'b01);
      cyc(1);
      check("tmo_fault", {29'd0, fault, busy, pid_en}, 32'b101);
      check("tmo_no_pulses", clk_en_pulses * 256 + valid_pulses, 32'h0404);
      run = 1'b0;
      cyc(1);
      check("fault_cleared", {31'd0, fault}, 32'd0);
`else
      cyc(11);
      check("wait_meas_indefinite", {30'd0, fault, busy}, 32'b01);
      run = 1'b0;
      cyc(1);
`endif

      // Reset mid-sample aborts without a clk_en pulse
      run = 1'b1;
      wait_req("req_rst", r6);
      cyc(3);
      meas_valid = 1'b1; meas_data = 9'd55;
      reset = 1'b1;
      cyc(2);
      meas_valid = 1'b0;
      check("rst_abort_no_pulse", clk_en_pulses, 32'd4);
      check("rst_mid_flags", {26'd0, pid_en, pid_clk_en, meas_req, ctrl_valid, busy, overrun},
            32'd0);
      check("rst_mid_regs", {ctrl_out, pid_k_p}, 32'd0);
      reset = 1'b0;
      wait_req("req_after_rst", r7);
      check("shadow_cleared", {pid_k_p, pid_k_i}, 32'd0);
      run = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
